// File: rtl/pulse_emitter_if.sv
//------------------------------------------------------------------------------
// pulse_emitter_if : request handshake and pulse-train outputs of pulse_emitter
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pulse_emitter_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             pulse;
    logic [WIDTH-1:0] remaining;
    logic             busy;
    logic             done;

`ifdef PULSE_EMITTER_ABORT_EN
    logic             abort;

    modport master (
        output in_valid, in_data, abort,
        input  in_ready, pulse, remaining, busy, done
    );
    modport slave (
        input  in_valid, in_data, abort,
        output in_ready, pulse, remaining, busy, done
    );
`else
    modport master (
        output in_valid, in_data,
        input  in_ready, pulse, remaining, busy, done
    );
    modport slave (
        input  in_valid, in_data,
        output in_ready, pulse, remaining, busy, done
    );
`endif
endinterface

`default_nettype wire

// File: rtl/pulse_emitter.sv
//------------------------------------------------------------------------------
// pulse_emitter : emits N single-cycle pulses spaced by GAP idle cycles, then
// a done strobe. Optional cancel input enabled by PULSE_EMITTER_ABORT_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pulse_emitter #(
    parameter int WIDTH = 4,
    parameter int GAP   = 0
) (
    input  logic [1:0]            clock_reset,
    pulse_emitter_if.slave        bus
);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [7:0]       GAP_LAST = 8'((GAP > 0) ? (GAP - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    logic             clk;
    logic             rst_n;
    state_t           state_q;
    logic             pulse_q;
    logic             done_q;
    logic [WIDTH-1:0] remaining_q;
    logic [7:0]       gap_cnt_q;

    assign clk   = clock_reset[0];
    assign rst_n = clock_reset[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pulse_q     <= 1'b0;
            done_q      <= 1'b0;
            remaining_q <= '0;
            gap_cnt_q   <= '0;
        end
`ifdef PULSE_EMITTER_ABORT_EN
        else if (bus.abort && (state_q != S_IDLE)) begin
            state_q     <= S_IDLE;
            pulse_q     <= 1'b0;
            done_q      <= 1'b0;
            remaining_q <= '0;
            gap_cnt_q   <= '0;
        end
`endif
        else begin
            pulse_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.in_data == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q     <= S_PULSE;
                            pulse_q     <= 1'b1;
                            remaining_q <= bus.in_data - ONE;
                        end
                    end
                end
                S_PULSE: begin
                    // remaining_q is only decremented when nonzero, so it cannot wrap
                    if (remaining_q == '0) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end else if (GAP > 0) begin
                        state_q   <= S_GAP;
                        gap_cnt_q <= GAP_LAST;
                    end else begin
                        pulse_q     <= 1'b1;
                        remaining_q <= remaining_q - ONE;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == 8'd0) begin
                        state_q     <= S_PULSE;
                        pulse_q     <= 1'b1;
                        remaining_q <= remaining_q - ONE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE) && rst_n;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.pulse     = pulse_q;
    assign bus.done      = done_q;
    assign bus.remaining = remaining_q;

endmodule

`default_nettype wire

// File: tb/tb_pulse_emitter.sv
//------------------------------------------------------------------------------
// tb_pulse_emitter : directed self-checking bench, one DUT with GAP=0 and one
// with GAP=2 sharing clock and reset.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pulse_emitter;
    logic       clk;
    logic       rst_n;
    logic [1:0] clock_reset;
    int         tests_run;
    int         tests_failed;

    logic       cap_p [0:31];
    logic       cap_d [0:31];
    logic       cap_b [0:31];
    logic       cap_r [0:31];
    logic [3:0] cap_rem [0:31];

    assign clock_reset = {rst_n, clk};

    pulse_emitter_if #(.WIDTH(4)) if0 ();
    pulse_emitter_if #(.WIDTH(4)) if2 ();

    pulse_emitter #(.WIDTH(4), .GAP(0)) u_dut0 (.clock_reset(clock_reset), .bus(if0));
    pulse_emitter #(.WIDTH(4), .GAP(2)) u_dut2 (.clock_reset(clock_reset), .bus(if2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input bit sel, input logic v, input int n);
        if (sel) begin
            if2.in_valid = v;
            if2.in_data  = 4'(n);
        end else begin
            if0.in_valid = v;
            if0.in_data  = 4'(n);
        end
    endtask

    // Presents N at the current negedge and records cycles k+1..k+ncyc.
    // Optionally presents n2 in cycle j2; in_data is scrambled while busy.
    task automatic run(input bit sel, input int n, input int ncyc, input int j2, input int n2);
        drive(sel, 1'b1, n);
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            cap_p[i]   = sel ? if2.pulse     : if0.pulse;
            cap_d[i]   = sel ? if2.done      : if0.done;
            cap_b[i]   = sel ? if2.busy      : if0.busy;
            cap_r[i]   = sel ? if2.in_ready  : if0.in_ready;
            cap_rem[i] = sel ? if2.remaining : if0.remaining;
            if (i == j2)          drive(sel, 1'b1, n2);
            else if (i == j2 + 1) drive(sel, 1'b0, 0);
            else                  drive(sel, 1'b0, ~n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({if0.pulse, if0.done, if0.busy, if0.in_ready, if0.remaining} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_dut0: got p/d/b/rdy/rem=%b required 00000000",
                     {if0.pulse, if0.done, if0.busy, if0.in_ready, if0.remaining});
        end
        tests_run++;
        if ({if2.pulse, if2.done, if2.busy, if2.in_ready, if2.remaining} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_dut2: got p/d/b/rdy/rem=%b required 00000000",
                     {if2.pulse, if2.done, if2.busy, if2.in_ready, if2.remaining});
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({if0.in_ready, if2.in_ready, if0.busy, if2.busy} !== 4'b1100) begin
            tests_failed++;
            $display("FAIL reset_release: got rdy0/rdy2/busy0/busy2=%b required 1100",
                     {if0.in_ready, if2.in_ready, if0.busy, if2.busy});
        end
    endtask

    task automatic test_gap0_basic();
        logic [0:5] ep, ed, eb;
        int         er [6];
        ep = 6'b111000;
        ed = 6'b000100;
        eb = 6'b111000;
        er = '{2, 1, 0, 0, 0, 0};
        run(1'b0, 3, 6, 0, 0);
        for (int i = 0; i < 6; i++) begin
            tests_run++;
            if ({cap_p[i+1], cap_d[i+1], cap_b[i+1], cap_rem[i+1]} !==
                {ep[i], ed[i], eb[i], 4'(er[i])}) begin
                tests_failed++;
                $display("FAIL gap0_n3 cyc%0d: got p/d/b/rem=%b%b%b/%0d required %b%b%b/%0d",
                         i+1, cap_p[i+1], cap_d[i+1], cap_b[i+1], cap_rem[i+1],
                         ep[i], ed[i], eb[i], er[i]);
            end
        end
        tests_run++;
        if (cap_r[4] !== 1'b1) begin
            tests_failed++;
            $display("FAIL gap0_n3 ready_in_done: got %b required 1", cap_r[4]);
        end
    endtask

    task automatic test_gap2();
        logic [0:9] ep, ed, eb;
        int         er [10];
        ep = 10'b1001001000;
        ed = 10'b0000000100;
        eb = 10'b1111111000;
        er = '{2, 2, 2, 1, 1, 1, 0, 0, 0, 0};
        run(1'b1, 3, 10, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tests_run++;
            if ({cap_p[i+1], cap_d[i+1], cap_b[i+1], cap_rem[i+1]} !==
                {ep[i], ed[i], eb[i], 4'(er[i])}) begin
                tests_failed++;
                $display("FAIL gap2_n3 cyc%0d: got p/d/b/rem=%b%b%b/%0d required %b%b%b/%0d",
                         i+1, cap_p[i+1], cap_d[i+1], cap_b[i+1], cap_rem[i+1],
                         ep[i], ed[i], eb[i], er[i]);
            end
        end
    endtask

    task automatic test_zero_then_max();
        int npulse, ndone;
        run(1'b0, 0, 1, 0, 0);
        tests_run++;
        if ({cap_p[1], cap_d[1], cap_b[1], cap_r[1]} !== 4'b0101) begin
            tests_failed++;
            $display("FAIL n0: got p/d/b/rdy=%b required 0101",
                     {cap_p[1], cap_d[1], cap_b[1], cap_r[1]});
        end
        run(1'b0, 15, 17, 0, 0);
        npulse = 0;
        ndone  = 0;
        for (int i = 1; i <= 17; i++) begin
            npulse += int'(cap_p[i]);
            ndone  += int'(cap_d[i]);
        end
        for (int i = 1; i <= 15; i++) begin
            tests_run++;
            if ({cap_p[i], cap_rem[i]} !== {1'b1, 4'(15 - i)}) begin
                tests_failed++;
                $display("FAIL n15 cyc%0d: got p/rem=%b/%0d required 1/%0d",
                         i, cap_p[i], cap_rem[i], 15 - i);
            end
        end
        tests_run++;
        if ({cap_p[16], cap_d[16], cap_b[16], cap_r[16], cap_rem[16]} !== 8'b0101_0000) begin
            tests_failed++;
            $display("FAIL n15 done_cyc: got p/d/b/rdy/rem=%b required 01010000",
                     {cap_p[16], cap_d[16], cap_b[16], cap_r[16], cap_rem[16]});
        end
        tests_run++;
        if (npulse != 15 || ndone != 1) begin
            tests_failed++;
            $display("FAIL n15 totals: got pulses=%0d dones=%0d required 15 and 1", npulse, ndone);
        end
    endtask

    task automatic test_back_to_back();
        logic [0:5] ep, ed;
        ep = 6'b110100;
        ed = 6'b001010;
        run(1'b0, 2, 6, 3, 1);
        for (int i = 0; i < 6; i++) begin
            tests_run++;
            if ({cap_p[i+1], cap_d[i+1]} !== {ep[i], ed[i]}) begin
                tests_failed++;
                $display("FAIL b2b cyc%0d: got p/d=%b%b required %b%b",
                         i+1, cap_p[i+1], cap_d[i+1], ep[i], ed[i]);
            end
        end
        tests_run++;
        if (cap_r[3] !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b ready_in_done: got %b required 1", cap_r[3]);
        end
    endtask

    task automatic test_reset_mid_train();
        int bad;
        run(1'b0, 5, 2, 0, 0);
        tests_run++;
        if ({cap_p[1], cap_p[2]} !== 2'b11) begin
            tests_failed++;
            $display("FAIL rst_mid pre_pulses: got %b required 11", {cap_p[1], cap_p[2]});
        end
        rst_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({if0.pulse, if0.done, if0.busy, if0.in_ready, if0.remaining} !== 8'h00) begin
            tests_failed++;
            $display("FAIL rst_mid in_reset: got p/d/b/rdy/rem=%b required 00000000",
                     {if0.pulse, if0.done, if0.busy, if0.in_ready, if0.remaining});
        end
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if ({if0.pulse, if0.done, if0.busy, if0.in_ready} !== 4'b0001) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL rst_mid after_release: got %0d bad cycles required 0", bad);
        end
    endtask

`ifdef PULSE_EMITTER_ABORT_EN
    task automatic test_abort();
        int bad;
        run(1'b0, 6, 2, 0, 0);
        if0.abort = 1'b1;
        @(negedge clk);
        if0.abort = 1'b0;
        tests_run++;
        if ({cap_p[1], cap_p[2], if0.pulse, if0.done, if0.busy, if0.in_ready, if0.remaining}
            !== 10'b11_0001_0000) begin
            tests_failed++;
            $display("FAIL abort: got p1/p2/p/d/b/rdy/rem=%b required 1100010000",
                     {cap_p[1], cap_p[2], if0.pulse, if0.done, if0.busy, if0.in_ready, if0.remaining});
        end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if ({if0.pulse, if0.done} !== 2'b00) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL abort after: got %0d bad cycles required 0", bad);
        end
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        drive(1'b0, 1'b0, 0);
        drive(1'b1, 1'b0, 0);
`ifdef PULSE_EMITTER_ABORT_EN
        if0.abort = 1'b0;
        if2.abort = 1'b0;
`endif
        test_reset();
        test_gap0_basic();
        test_gap2();
        test_zero_then_max();
        test_back_to_back();
        test_reset_mid_train();
`ifdef PULSE_EMITTER_ABORT_EN
        test_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/pulse_emitter.md
# pulse_emitter

Converts a count into a train of single-cycle pulses: the inverse of the enable-driven up-counter. A producer hands over a WIDTH-bit count N on a valid/ready handshake, and the block emits exactly N one-cycle `pulse` strobes, spaced by a programmable gap, then flags completion. It sits upstream of counter-style blocks, driving their 1-bit enable input, and is used to replay a stored count into them.

## Interface
Parameters:
- WIDTH, 4, width of the count and `remaining`.
- GAP, 0, low cycles inserted between consecutive pulses (0..255).

Ports:
- clock_reset  input  2  bit 0 = clock, bit 1 = reset; one clock; reset is synchronous and active-low.
- in_valid  input  1  count request valid.
- in_data  input  WIDTH  count N to emit.
- in_ready  output  1  block can accept a request.
- pulse  output  1  one-cycle output strobe, registered.
- remaining  output  WIDTH  pulses still to be emitted after the current cycle, registered.
- busy  output  1  high while a train is in progress.
- done  output  1  one-cycle completion strobe, registered.
- abort  input  1  cancel the current train (present only with PULSE_EMITTER_ABORT_EN).

## Operation
- States:
  - IDLE: `busy`=0 and `in_ready`=1. Accept the request on `in_valid && in_ready` at a rising edge.
  - PULSE: `pulse`=1 for exactly one cycle.
  - GAP: `pulse`=0; lasts GAP cycles.
- Transitions on accept of N:
  - N=0: stay in IDLE; `done`=1 in the next cycle; no pulses.
  - N>0: go to PULSE and load `remaining`=N-1.
- PULSE:
  - If `remaining`=0, go to IDLE and set `done` for one cycle.
  - Otherwise, if GAP>0, go to GAP; else go to PULSE again and decrement `remaining`.
- GAP: count GAP cycles, then go to PULSE and decrement `remaining`.
- Values:
  - `in_ready` = (state==IDLE) && reset deasserted. It is combinational from state and clock_reset[1].
  - `busy` = (state!=IDLE).
- `in_data` is sampled only at accept. Changes while busy are ignored.
- `remaining` is an unsigned WIDTH-bit value and never wraps below 0. An N of all-ones, e.g. 15 at WIDTH=4, produces exactly 2^WIDTH-1 pulses.
- Reset (clock_reset[1]=0 at a rising edge), from any state including mid-train:
  - state=IDLE, `pulse`=0, `done`=0, `remaining`=0, gap counter=0.
  - `in_ready`=0 while reset is low; `in_ready`=1 in the first cycle after release.
  - No `done` is generated for an interrupted train.

## Timing
- Request accepted at edge k: first `pulse` in cycle k+1.
- Pulse i (1..N) is high in cycle k+1+(i-1)(GAP+1).
- Last pulse falls in cycle k+N+(N-1)·GAP.
- `done` is high in the cycle after the last pulse. `in_ready` is also high in that cycle, so back-to-back requests are allowed. The next train's first pulse follows the done cycle by one cycle.
- `busy` is high from cycle k+1 through the last-pulse cycle inclusive.
- Pulse spacing is exact. There is no trailing gap after the last pulse.

## Configuration
- PULSE_EMITTER_ABORT_EN defined:
  - The `abort` port exists.
  - `abort`=1 in any busy cycle forces state=IDLE, `pulse`=0 and `remaining`=0 at the next edge, with no `done`.
  - A pulse already high in the abort cycle still counts as emitted.
  - `abort` in IDLE is ignored.
  - Reset takes priority over abort.
- PULSE_EMITTER_ABORT_EN not defined: there is no `abort` port, and every accepted train runs to completion or reset.

## Test plan
- After reset release, WIDTH=4, GAP=0: accept N=3 at edge k -> `pulse` high in cycles k+1, k+2, k+3; `remaining` reads 2,1,0; `done` in k+4 with `in_ready`=1.
- GAP=2, N=3 -> pulses in cycles k+1, k+4, k+7; `busy` high for 7 cycles; `done` in k+8.
- N=0 -> no pulse; `done` in k+1; `busy` stays 0. Then N=15 -> exactly 15 pulses, and `remaining` never wraps.
- Back-to-back: N=2 then N=1 presented in the `done` cycle -> 3 pulses total, with a one-cycle gap containing `done` between the trains.
- Reset asserted for 1 cycle after the 2nd pulse of N=5 -> no further pulses, no `done`, all outputs 0, `in_ready`=0 during reset and 1 after release.
- With PULSE_EMITTER_ABORT_EN: abort in the 2nd pulse cycle of N=6 -> exactly 2 pulses, no `done`, `in_ready`=1 the next cycle.
